// File: rtl/btb_pkg.sv
// Shared BTB constants, field positions and update-path types.
package btb_pkg;

  localparam int          BTB_NENT    = 128;
  localparam logic [7:0]  BTB_INV_TAG = 8'hFF;
  localparam logic [15:0] BTB_INV_TGT = 16'hFFFF;

  // Index is PC[7:1], tag is PC[15:8].
  localparam int BTB_IDX_LSB = 1;
  localparam int BTB_IDX_MSB = 7;
  localparam int BTB_TAG_LSB = 8;
  localparam int BTB_TAG_MSB = 15;

  typedef enum logic [0:0] {
    FLUSH = 1'b0,
    RUN   = 1'b1
  } btb_state_e;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] target;
  } btb_upd_t;

  function automatic logic [15:0] btb_inv_pc(input logic [6:0] idx);
    return {BTB_INV_TAG, idx, 1'b0};
  endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Update FIFO: two ordered pushes (a before b), one pop, synchronous clear.
module btb_upd_fifo
  import btb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push_a,
  input  logic          push_b,
  input  btb_upd_t      data_a,
  input  btb_upd_t      data_b,
  input  logic          pop,
  output btb_upd_t      head,
  output logic          empty,
  output logic [AW:0]   count
);

  btb_upd_t        mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   wr_ptr_b;

  // b lands behind a when both push, otherwise at the tail itself.
  assign wr_ptr_b = wr_ptr + AW'(push_a);

  always_ff @(posedge clk) begin
    if (push_a) mem[wr_ptr]   <= data_a;
    if (push_b) mem[wr_ptr_b] <= data_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_a) + AW'(push_b);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(push_a) + (AW+1)'(push_b) - (AW+1)'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/btb_update_ctrl.sv
// Single owner of the BTB write port: invalidate walk after reset/flush,
// then drains filtered branch-resolution updates from pipes A and B.
module btb_update_ctrl
  import btb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NENT  = BTB_NENT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        updA_valid,
  input  logic        updA_taken,
  input  logic [15:0] updA_PC,
  input  logic [15:0] updA_target,
  input  logic        updB_valid,
  input  logic        updB_taken,
  input  logic [15:0] updB_PC,
  input  logic [15:0] updB_target,
  output logic        upd_ready,
  input  logic        flush,
  output logic        busy,
  output logic        WE,
  output logic [15:0] PCW,
  output logic [15:0] targetW
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(NENT);

  btb_state_e     state;
  logic [IW-1:0]  idx;
  logic [CW-1:0]  count;
  logic           empty;
  btb_upd_t       head;
  btb_upd_t       data_a;
  btb_upd_t       data_b;
  logic           qual_a;
  logic           qual_b;
  logic           dup;
  logic           push_a;
  logic           push_b;
  logic           pop;

  assign busy      = (state == FLUSH);
  // Threshold leaves room for a 2-wide push without counting this cycle's pop.
  assign upd_ready = (state == RUN) && (count <= CW'(DEPTH - 2));

  assign qual_a = updA_valid && updA_taken && upd_ready && !flush;
  assign qual_b = updB_valid && updB_taken && upd_ready && !flush;
  // B is younger, so it wins a same-PC collision.
  assign dup    = qual_a && qual_b && (updA_PC == updB_PC);
  assign push_a = qual_a && !dup;
  assign push_b = qual_b;
  assign pop    = (state == RUN) && !empty && !flush;

  assign data_a = '{pc: updA_PC, target: updA_target};
  assign data_b = '{pc: updB_PC, target: updB_target};

  btb_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (flush || (state == FLUSH)),
    .push_a (push_a),
    .push_b (push_b),
    .data_a (data_a),
    .data_b (data_b),
    .pop    (pop),
    .head   (head),
    .empty  (empty),
    .count  (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FLUSH;
      idx     <= '0;
      WE      <= 1'b0;
      PCW     <= '0;
      targetW <= '0;
    end else if (flush) begin
      // Queued updates are dropped; the walk restarts on the next edge.
      state   <= FLUSH;
      idx     <= '0;
      WE      <= 1'b0;
    end else if (state == FLUSH) begin
      WE      <= 1'b1;
      PCW     <= btb_inv_pc(7'(idx));
      targetW <= BTB_INV_TGT;
      idx     <= idx + 1'b1;
      if (idx == IW'(NENT - 1)) state <= RUN;
    end else if (pop) begin
      WE      <= 1'b1;
      PCW     <= head.pc;
      targetW <= head.target;
    end else begin
      WE      <= 1'b0;
    end
  end

endmodule
